// File: rtl/ppu_regs.sv
// CPU-facing PPU register file ($2000-$2007): control/mask, loopy scroll state,
// OAM address/data port, buffered PPUDATA access FSM and vblank/NMI generation.
module ppu_regs #(
    parameter logic [8:0] VBL_SET_LINE = 9'd241,
    parameter logic [8:0] PRE_LINE     = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [2:0]  ain,
    input  logic [7:0]  din,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  dout,
    input  logic [8:0]  scanline,
    input  logic [8:0]  cycle,
    input  logic        spr0_hit_set,
    input  logic        spr_ovf_set,
    input  logic        render_v_we,
    input  logic [14:0] render_v_in,
    output logic [7:0]  ppuctrl,
    output logic [7:0]  ppumask,
    output logic [14:0] v,
    output logic [14:0] t,
    output logic [2:0]  fine_x,
    output logic        nmi,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_dout,
    input  logic [7:0]  oam_din,
    output logic        vram_r,
    output logic        vram_w,
    output logic [13:0] vram_a,
    output logic [7:0]  vram_dout,
    input  logic [7:0]  vram_din,
    output logic [1:0]  fsm_state
);

    // CPU handshake: read/write are single-clk strobes with ain/din valid in
    // the same clk; there is no back-pressure, a $7 strobe seen while the
    // access FSM is busy is simply dropped.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } vstate_t;

    vstate_t     state, state_nx;
    logic        w;
    logic        vbl, spr0, ovf;
    logic [7:0]  io_latch;
    logic [7:0]  rbuf;
    logic        op_wr;
    logic        acc7_rd, acc7_wr, acc7_go;
    logic        rd2;
    logic        vbl_set_evt, pre_evt;
    logic [14:0] v_inc;

    assign acc7_wr     = write && (ain == 3'd7);
    assign acc7_rd     = read  && (ain == 3'd7);
    assign acc7_go     = (acc7_wr || acc7_rd) && (state == S_IDLE);
    assign rd2         = read && (ain == 3'd2);
    assign vbl_set_evt = ce && (scanline == VBL_SET_LINE) && (cycle == 9'd1);
    assign pre_evt     = ce && (scanline == PRE_LINE) && (cycle == 9'd1);
    assign v_inc       = v + (ppuctrl[2] ? 15'd32 : 15'd1);

    // Strobes decode from the registered state, so reset removes them at once.
    assign vram_r    = (state == S_REQ) && !op_wr;
    assign vram_w    = (state == S_REQ) && op_wr;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (acc7_go) state_nx = S_REQ;
            S_REQ:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppuctrl   <= 8'h00;
            ppumask   <= 8'h00;
            t         <= 15'h0000;
            v         <= 15'h0000;
            fine_x    <= 3'd0;
            w         <= 1'b0;
            io_latch  <= 8'h00;
            oam_addr  <= 8'h00;
            oam_dout  <= 8'h00;
            oam_we    <= 1'b0;
            dout      <= 8'h00;
            vbl       <= 1'b0;
            spr0      <= 1'b0;
            ovf       <= 1'b0;
            nmi       <= 1'b0;
            rbuf      <= 8'h00;
            op_wr     <= 1'b0;
            vram_a    <= 14'h0000;
            vram_dout <= 8'h00;
        end else begin
            oam_we <= 1'b0;

            if (write) begin
                io_latch <= din;
                case (ain)
                    3'd0: begin
                        ppuctrl   <= din;
                        t[11:10]  <= din[1:0];
                    end
                    3'd1: ppumask <= din;
                    3'd3: oam_addr <= din;
                    3'd4: begin
                        oam_dout <= din;
                        oam_we   <= 1'b1;
                        oam_addr <= oam_addr + 8'd1;
                    end
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= din[7:3];
                            fine_x <= din[2:0];
                        end else begin
                            t[14:12] <= din[2:0];
                            t[9:5]   <= din[7:3];
                        end
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= din[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0] <= din;
                        end
                        w <= ~w;
                    end
                    default: ;
                endcase
            end

            // CPU address load beats the PPUDATA increment beats the renderer.
            if (write && (ain == 3'd6) && w)
                v <= {t[14:8], din};
            else if (state == S_DONE)
                v <= v_inc;
            else if (render_v_we)
                v <= render_v_in;

            if (read) begin
                case (ain)
                    3'd2:    dout <= {vbl, spr0, ovf, io_latch[4:0]};
                    3'd4:    dout <= oam_din;
                    3'd7:    dout <= rbuf;
                    default: dout <= io_latch;
                endcase
            end
            if (rd2) w <= 1'b0;

            // A status read coinciding with the set point wins, suppressing vblank.
            if (pre_evt) begin
                vbl  <= 1'b0;
                spr0 <= 1'b0;
                ovf  <= 1'b0;
            end else if (vbl_set_evt && !rd2) begin
                vbl <= 1'b1;
            end
            if (rd2)          vbl  <= 1'b0;
            if (spr0_hit_set) spr0 <= 1'b1;
            if (spr_ovf_set)  ovf  <= 1'b1;

            nmi <= vbl & ppuctrl[7];

            if (acc7_go) begin
                op_wr  <= acc7_wr;
                vram_a <= v[13:0];
                if (acc7_wr) vram_dout <= din;
            end
            if ((state == S_DONE) && !op_wr)
                rbuf <= vram_din;
        end
    end

endmodule

// File: tb/tb_ppu_regs.sv
// Directed bench for ppu_regs: register decode, loopy scroll, PPUDATA FSM,
// vblank/NMI timing and the status-read race.
module tb_ppu_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [2:0]  ain = 3'd0;
    logic [7:0]  din = 8'h00;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  dout;
    logic [8:0]  scanline = 9'd0;
    logic [8:0]  cycle = 9'd0;
    logic        spr0_hit_set = 1'b0;
    logic        spr_ovf_set = 1'b0;
    logic        render_v_we = 1'b0;
    logic [14:0] render_v_in = 15'h0;
    logic [7:0]  ppuctrl, ppumask;
    logic [14:0] v, t;
    logic [2:0]  fine_x;
    logic        nmi;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_dout;
    logic [7:0]  oam_din = 8'h00;
    logic        vram_r, vram_w;
    logic [13:0] vram_a;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din = 8'h00;
    logic [1:0]  fsm_state;

    int checks = 0;
    int failures = 0;

    ppu_regs dut (
        .clk(clk), .reset(reset), .ce(ce), .ain(ain), .din(din),
        .read(read), .write(write), .dout(dout),
        .scanline(scanline), .cycle(cycle),
        .spr0_hit_set(spr0_hit_set), .spr_ovf_set(spr_ovf_set),
        .render_v_we(render_v_we), .render_v_in(render_v_in),
        .ppuctrl(ppuctrl), .ppumask(ppumask), .v(v), .t(t), .fine_x(fine_x),
        .nmi(nmi), .oam_addr(oam_addr), .oam_we(oam_we), .oam_dout(oam_dout),
        .oam_din(oam_din), .vram_r(vram_r), .vram_w(vram_w), .vram_a(vram_a),
        .vram_dout(vram_dout), .vram_din(vram_din), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b1;
        ce = 1'b0; read = 1'b0; write = 1'b0; render_v_we = 1'b0;
        spr0_hit_set = 1'b0; spr_ovf_set = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge after the strobe edge, where the response is visible.
    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        ain = a; din = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [2:0] a);
        @(negedge clk);
        ain = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic timing_pulse(input logic [8:0] sl, input logic [8:0] cy);
        @(negedge clk);
        ce = 1'b1; scanline = sl; cycle = cy;
        @(negedge clk);
        ce = 1'b0; scanline = 9'd0; cycle = 9'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_dout: got %h expected %h", dout, 8'h00); end
        checks++; if (v !== 15'h0) begin failures++; $display("FAIL rst_v: got %h expected %h", v, 15'h0); end
        checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL rst_nmi: got %b expected 0", nmi); end
        checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
        cpu_wr(3'd6, 8'h21); idle(2);
        cpu_wr(3'd6, 8'h08); idle(2);
        cpu_wr(3'd0, 8'h80); idle(2);
        cpu_wr(3'd7, 8'hAB);
        checks++; if (vram_w !== 1'b1) begin failures++; $display("FAIL rst_pre_vram_w: got %b expected 1", vram_w); end
        #1 reset = 1'b1;
        #1;
        checks++; if (vram_w !== 1'b0) begin failures++; $display("FAIL rst_mid_vram_w: got %b expected 0", vram_w); end
        checks++; if (v !== 15'h0) begin failures++; $display("FAIL rst_mid_v: got %h expected %h", v, 15'h0); end
        checks++; if (t !== 15'h0) begin failures++; $display("FAIL rst_mid_t: got %h expected %h", t, 15'h0); end
        checks++; if (ppuctrl !== 8'h00) begin failures++; $display("FAIL rst_mid_ctrl: got %h expected %h", ppuctrl, 8'h00); end
        checks++; if (nmi !== 1'b0 || dout !== 8'h00) begin failures++; $display("FAIL rst_mid_nmi_dout: got %b/%h expected 0/00", nmi, dout); end
        @(negedge clk);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_vram_write();
        do_reset();
        cpu_wr(3'd6, 8'h21); idle(2);
        cpu_wr(3'd6, 8'h08); idle(2);
        checks++; if (v !== 15'h2108) begin failures++; $display("FAIL wr_v_load: got %h expected %h", v, 15'h2108); end
        cpu_wr(3'd7, 8'hAB);
        checks++; if (vram_w !== 1'b1 || vram_r !== 1'b0) begin failures++; $display("FAIL wr_strobe: got w=%b r=%b expected w=1 r=0", vram_w, vram_r); end
        checks++; if (vram_a !== 14'h2108) begin failures++; $display("FAIL wr_addr: got %h expected %h", vram_a, 14'h2108); end
        checks++; if (vram_dout !== 8'hAB) begin failures++; $display("FAIL wr_data: got %h expected %h", vram_dout, 8'hAB); end
        idle(2);
        checks++; if (v !== 15'h2109) begin failures++; $display("FAIL wr_v_inc: got %h expected %h", v, 15'h2109); end
        checks++; if (vram_w !== 1'b0) begin failures++; $display("FAIL wr_strobe_end: got %b expected 0", vram_w); end
    endtask

    task automatic test_vram_read();
        do_reset();
        cpu_wr(3'd6, 8'h20); idle(2);
        cpu_wr(3'd6, 8'h00); idle(2);
        vram_din = 8'h55;
        cpu_rd(3'd7);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rd1_dout: got %h expected %h", dout, 8'h00); end
        checks++; if (vram_r !== 1'b1 || vram_a !== 14'h2000) begin failures++; $display("FAIL rd1_req: got r=%b a=%h expected r=1 a=2000", vram_r, vram_a); end
        idle(2);
        vram_din = 8'h66;
        cpu_rd(3'd7);
        checks++; if (dout !== 8'h55) begin failures++; $display("FAIL rd2_dout: got %h expected %h", dout, 8'h55); end
        idle(2);
        checks++; if (v !== 15'h2002) begin failures++; $display("FAIL rd_v: got %h expected %h", v, 15'h2002); end
        cpu_rd(3'd7);
        checks++; if (dout !== 8'h66) begin failures++; $display("FAIL rd3_dout: got %h expected %h", dout, 8'h66); end
        idle(2);
    endtask

    task automatic test_wrap();
        do_reset();
        cpu_wr(3'd0, 8'h04); idle(2);
        @(negedge clk);
        render_v_in = 15'h7FF0; render_v_we = 1'b1;
        @(negedge clk);
        render_v_we = 1'b0;
        checks++; if (v !== 15'h7FF0) begin failures++; $display("FAIL render_load: got %h expected %h", v, 15'h7FF0); end
        cpu_wr(3'd7, 8'h12);
        checks++; if (vram_a !== 14'h3FF0) begin failures++; $display("FAIL wrap_addr: got %h expected %h", vram_a, 14'h3FF0); end
        idle(2);
        checks++; if (v !== 15'h0010) begin failures++; $display("FAIL wrap_v: got %h expected %h", v, 15'h0010); end
    endtask

    task automatic test_vblank();
        do_reset();
        cpu_wr(3'd5, 8'h03); idle(2);
        cpu_wr(3'd0, 8'h80); idle(2);
        timing_pulse(9'd241, 9'd1);
        checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_early: got %b expected 0", nmi); end
        @(negedge clk);
        checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_set: got %b expected 1", nmi); end
        cpu_rd(3'd2);
        checks++; if (dout !== 8'h80) begin failures++; $display("FAIL status_vbl: got %h expected %h", dout, 8'h80); end
        idle(2);
        checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_clear: got %b expected 0", nmi); end
        cpu_wr(3'd5, 8'h06); idle(2);
        checks++; if (fine_x !== 3'd6) begin failures++; $display("FAIL w_cleared: got fine_x=%0d expected 6", fine_x); end
        @(negedge clk); spr0_hit_set = 1'b1; spr_ovf_set = 1'b1;
        @(negedge clk); spr0_hit_set = 1'b0; spr_ovf_set = 1'b0;
        timing_pulse(9'd241, 9'd1); idle(1);
        cpu_rd(3'd2);
        checks++; if (dout !== 8'hE6) begin failures++; $display("FAIL status_flags: got %h expected %h", dout, 8'hE6); end
        idle(2);
        timing_pulse(9'd241, 9'd1); idle(1);
        checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_reset2: got %b expected 1", nmi); end
        timing_pulse(9'h1FF, 9'd1); idle(1);
        checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_pre: got %b expected 0", nmi); end
        cpu_rd(3'd2);
        checks++; if (dout !== 8'h06) begin failures++; $display("FAIL status_pre: got %h expected %h", dout, 8'h06); end
        idle(2);
    endtask

    task automatic test_race();
        do_reset();
        cpu_wr(3'd0, 8'h80); idle(2);
        @(negedge clk);
        ce = 1'b1; scanline = 9'd241; cycle = 9'd1; ain = 3'd2; read = 1'b1;
        @(negedge clk);
        ce = 1'b0; scanline = 9'd0; cycle = 9'd0; read = 1'b0;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL race_dout: got %h expected %h", dout, 8'h00); end
        idle(3);
        checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL race_nmi: got %b expected 0", nmi); end
        cpu_rd(3'd2);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL race_vbl: got %h expected %h", dout, 8'h00); end
        idle(2);
    endtask

    task automatic test_scroll_oam();
        do_reset();
        cpu_wr(3'd5, 8'h7D); idle(2);
        cpu_wr(3'd5, 8'h5E); idle(2);
        checks++; if (fine_x !== 3'd5) begin failures++; $display("FAIL fine_x: got %0d expected 5", fine_x); end
        checks++; if (t !== 15'h616F) begin failures++; $display("FAIL scroll_t: got %h expected %h", t, 15'h616F); end
        cpu_wr(3'd0, 8'h03); idle(2);
        checks++; if (t !== 15'h6D6F || ppuctrl !== 8'h03) begin failures++; $display("FAIL ctrl_t: got t=%h ctrl=%h expected t=6d6f ctrl=03", t, ppuctrl); end
        cpu_wr(3'd1, 8'h1E); idle(2);
        checks++; if (ppumask !== 8'h1E) begin failures++; $display("FAIL mask: got %h expected %h", ppumask, 8'h1E); end
        cpu_rd(3'd1);
        checks++; if (dout !== 8'h1E) begin failures++; $display("FAIL io_latch: got %h expected %h", dout, 8'h1E); end
        idle(2);
        cpu_wr(3'd3, 8'hFF); idle(2);
        cpu_wr(3'd4, 8'hC7);
        checks++; if (oam_we !== 1'b1 || oam_dout !== 8'hC7) begin failures++; $display("FAIL oam_wr: got we=%b d=%h expected we=1 d=c7", oam_we, oam_dout); end
        checks++; if (oam_addr !== 8'h00) begin failures++; $display("FAIL oam_wrap: got %h expected %h", oam_addr, 8'h00); end
        @(negedge clk);
        checks++; if (oam_we !== 1'b0) begin failures++; $display("FAIL oam_we_pulse: got %b expected 0", oam_we); end
        idle(1);
        oam_din = 8'h3C;
        cpu_rd(3'd4);
        checks++; if (dout !== 8'h3C) begin failures++; $display("FAIL oam_rd: got %h expected %h", dout, 8'h3C); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        cpu_wr(3'd6, 8'h3F); idle(2);
        cpu_wr(3'd6, 8'hF0); idle(2);
        pulses = 0;
        @(negedge clk);
        ain = 3'd7; din = 8'h11; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        if (vram_w === 1'b1) pulses++;
        @(negedge clk);
        din = 8'h22; write = 1'b1;
        if (vram_w === 1'b1) pulses++;
        @(negedge clk);
        write = 1'b0;
        if (vram_w === 1'b1) pulses++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (vram_w === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
        checks++; if (v !== 15'h3FF1) begin failures++; $display("FAIL busy_v: got %h expected %h", v, 15'h3FF1); end
        checks++; if (vram_dout !== 8'h11) begin failures++; $display("FAIL busy_data: got %h expected %h", vram_dout, 8'h11); end
    endtask

    initial begin
        test_reset();
        test_vram_write();
        test_vram_read();
        test_wrap();
        test_vblank();
        test_race();
        test_scroll_oam();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
